des_final_perm_stage: RTL and testbench
=======================================

Name: des_final_perm_stage

Overview:
- Output end of the DES datapath: the inverse of the initial permutation stage.
- Accepts the round-16 result (L16, R16) and optionally swaps the halves into the preoutput R16||L16.
- Applies the final permutation IP^-1 and delivers the 64-bit ciphertext/plaintext block through a 2-entry registered output buffer.
- Uses a valid/ready handshake on both sides.

Parameters:
- SWAP_HALVES, 1, 1 = swap the 32-bit halves before IP^-1 (normal DES); 0 = apply IP^-1 to the input as-is.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  in_block is valid
- in_ready  output  1  stage can accept a block this cycle
- in_block  input  [1:64]  L16 in bits 1..32, R16 in bits 33..64; DES bit numbering, bit 1 = MSB
- out_valid  output  1  out_block is valid
- out_ready  input  1  downstream accepts out_block
- out_block  output  [1:64]  IP^-1 result, bit 1 = MSB
- blk_count  output  CNT_W  number of completed output transfers, wraps modulo 2^CNT_W
- selfchk_err  output  1  sticky self-check failure; only meaningful with DES_FP_SELFCHECK_EN

Behaviour:
- Reset (rst_n low at clk edge):
  - Buffer emptied; out_valid=0, out_block=0, blk_count=0, selfchk_err=0.
  - in_ready is 0 during the reset cycle and 1 on the first cycle after reset.
  - Reset mid-operation discards all buffered blocks; no partial output.
- Preoutput:
  - pre = SWAP_HALVES ? {in_block[33:64], in_block[1:32]} : in_block.
  - Permutation is purely combinational, with no arithmetic.
- Final permutation: out[i] = pre[FP[i]], with FP = 40 8 48 16 56 24 64 32 / 39 7 47 15 55 23 63 31 / 38 6 46 14 54 22 62 30 / 37 5 45 13 53 21 61 29 / 36 4 44 12 52 20 60 28 / 35 3 43 11 51 19 59 27 / 34 2 42 10 50 18 58 26 / 33 1 41 9 49 17 57 25.
- Buffer:
  - 2-entry FIFO with occupancy 0..2.
  - Input transfer occurs when in_valid & in_ready; the permuted block is written into the buffer.
  - Latency: a block accepted at edge N is visible on out_block/out_valid after edge N (1 cycle).
- in_ready = (occupancy < 2). It depends only on registered state; there is no combinational path from out_ready.
- out_valid = (occupancy > 0); out_block = head entry.
- Output transfer occurs when out_valid & out_ready; the head is popped.
- Simultaneous push and pop at occupancy 1 or 2: occupancy is unchanged and order is preserved.
- At occupancy 0 with push and no pop: occupancy becomes 1.
- Full (2): in_ready=0; an in_valid held high is not accepted and is not lost.
- Empty: out_ready is ignored.
- Order is strictly FIFO; no block is dropped or duplicated.
- While out_valid=1 and out_ready=0, out_block is held stable.
- blk_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro: DES_FP_SELFCHECK_EN.
- Defined:
  - Each buffer entry also stores pre.
  - On each output transfer, the initial permutation is applied to out_block and compared with the stored pre.
  - A mismatch sets selfchk_err, which stays set until reset.
- Not defined: no pre storage and no IP logic; selfchk_err is tied to 0.

Decomposition:
- Shared package des_pkg:
  - des_block_t (64-bit, [1:64] ordering), des_half_t (32-bit).
  - Localparam arrays IP_TABLE[1:64] and FP_TABLE[1:64].
  - Functions des_ip() and des_fp() built from those tables, so the existing initial-permutation logic and this stage share one source of truth.
- One sub-module: des_fp_fifo2, a 2-entry valid/ready buffer parameterized on payload width (64, or 128 with self-check).

Test Plan:
- Known vector, SWAP_HALVES=1: in_block=0x434232340A4CD995 (L16, R16) with out_ready=1 -> one cycle later out_block=0x85E813540F0AB405, out_valid=1, then blk_count=1.
- Inverse check, SWAP_HALVES=0: in_block=0xCC00CCFFF0AAF0AA -> out_block=0x0123456789ABCDEF. Then random blocks x in a loop with des_ip(out)==x checked in the bench.
- Backpressure: out_ready=0 while pushing 3 blocks A,B,C -> A and B accepted, in_ready=0 with C held and out_block stable at A. Raise out_ready -> outputs A,B,C in order, none lost.
- Simultaneous push/pop at occupancy 2 and at occupancy 1 for 20 cycles with random out_ready -> occupancy conserved, output order matches the scoreboard.
- Counter wrap (CNT_W=4): 17 transfers -> blk_count reads 0 after the 16th transfer and 1 after the 17th.
- Reset mid-stream: occupancy=2, assert rst_n=0 for one edge -> out_valid=0, blk_count=0, selfchk_err=0, and no stale block emitted afterward. With DES_FP_SELFCHECK_EN, a forced corruption of a stored entry -> selfchk_err=1 on that transfer and stays set.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: shared DES permutation definitions.
//   des_block_t : 64-bit block, DES bit numbering [1:64], bit 1 = MSB
//   des_half_t  : 32-bit half block
//   IP_TABLE / FP_TABLE : initial and final permutation tables
//   des_ip() / des_fp() : table-driven permutations. The initial-permutation
//   stage and the final stage both use these, so the tables are defined once.
package des_pkg;

  typedef logic [1:64] des_block_t;
  typedef logic [1:32] des_half_t;

  localparam int IP_TABLE [1:64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TABLE [1:64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  function automatic des_block_t des_ip(input des_block_t blk);
    des_block_t r;
    for (int i = 1; i <= 64; i++) r[i] = blk[IP_TABLE[i]];
    return r;
  endfunction

  function automatic des_block_t des_fp(input des_block_t blk);
    des_block_t r;
    for (int i = 1; i <= 64; i++) r[i] = blk[FP_TABLE[i]];
    return r;
  endfunction

endpackage

// File: rtl/des_final_perm_stage_if.sv
// des_final_perm_stage_if: valid/ready handshake bundle for the final
// permutation stage.
//   in_valid/in_ready/in_block    : round-16 result into the stage
//   out_valid/out_ready/out_block : permuted block out of the stage
// Modports: slave = the stage's view, master = the driver/consumer view.
interface des_final_perm_stage_if;
  import des_pkg::*;

  logic       in_valid;
  logic       in_ready;
  des_block_t in_block;
  logic       out_valid;
  logic       out_ready;
  des_block_t out_block;

  modport master (
    output in_valid, in_block, out_ready,
    input  in_ready, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_block, out_ready,
    output in_ready, out_valid, out_block
  );

endinterface

// File: rtl/des_fp_fifo2.sv
// des_fp_fifo2: 2-entry valid/ready buffer, payload width W.
//   clk, rst_n     : clock, synchronous active-low reset
//   push_valid_i   : write request
//   push_ready_o   : space available (registered, no path from pop_ready_i)
//   push_data_i    : write payload
//   pop_valid_o    : head entry valid
//   pop_ready_i    : consumer takes head
//   pop_data_o     : head entry
// slot0 is always the head, so the output is a plain register read.
module des_fp_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         ready_q;
  logic         push, pop;

  assign push = push_valid_i & ready_q;
  assign pop  = pop_ready_i & (count_q != 2'd0);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = push_data_i;
        else                 slot1_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy stays the same; the new entry lands behind any survivor.
        if (count_q == 2'd1) begin
          slot0_d = push_data_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
      // Ready is computed from next occupancy so it is a pure flop output.
      ready_q <= (count_d != 2'd2);
    end
  end

  assign push_ready_o = ready_q;
  assign pop_valid_o  = (count_q != 2'd0);
  assign pop_data_o   = slot0_q;

endmodule

// File: rtl/des_final_perm_stage.sv
// des_final_perm_stage: DES output stage. Optionally swaps the round-16
// halves into R16||L16, applies IP^-1 and buffers the result in a 2-entry
// registered FIFO.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : in_valid/in_ready/in_block, out_valid/out_ready/out_block
//   blk_count    : completed output transfers, wraps modulo 2^CNT_W
//   selfchk_err  : sticky self-check failure
// Build option DES_FP_SELFCHECK_EN: each entry also keeps the preoutput,
// and every output transfer re-applies IP to the delivered block and compares.
// Without it selfchk_err is tied low.
module des_final_perm_stage
  import des_pkg::*;
#(
  parameter bit SWAP_HALVES = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  des_final_perm_stage_if.slave  bus,
  output logic [CNT_W-1:0]       blk_count,
  output logic                   selfchk_err
);

  des_block_t pre;
  des_block_t fp_blk;
  logic       out_fire;

  assign pre    = SWAP_HALVES ? {bus.in_block[33:64], bus.in_block[1:32]} : bus.in_block;
  assign fp_blk = des_fp(pre);

`ifdef DES_FP_SELFCHECK_EN
  localparam int PW = 128;
  logic [PW-1:0] push_data, head;
  des_block_t    head_pre;

  assign push_data     = {fp_blk, pre};
  assign bus.out_block = head[127:64];
  assign head_pre      = head[63:0];
`else
  localparam int PW = 64;
  logic [PW-1:0] push_data, head;

  assign push_data     = fp_blk;
  assign bus.out_block = head;
`endif

  des_fp_fifo2 #(.W(PW)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (bus.in_valid),
    .push_ready_o (bus.in_ready),
    .push_data_i  (push_data),
    .pop_valid_o  (bus.out_valid),
    .pop_ready_i  (bus.out_ready),
    .pop_data_o   (head)
  );

  assign out_fire = bus.out_valid & bus.out_ready;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign blk_count = cnt_q;

`ifdef DES_FP_SELFCHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (out_fire && (des_ip(bus.out_block) != head_pre)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign selfchk_err = err_q;
`else
  assign selfchk_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_final_perm_stage.sv
// Directed bench for des_final_perm_stage. Main instance: SWAP_HALVES=1,
// CNT_W=4. Second instance: SWAP_HALVES=0 for the inverse-permutation vector.
// The model keeps a queue of expected preoutputs; delivered blocks are
// checked by applying IP to them.
module tb_des_final_perm_stage;
  import des_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_final_perm_stage_if bus ();
  des_final_perm_stage_if bus_b ();

  logic [3:0]  blk_count;
  logic        selfchk_err;
  logic [15:0] blk_count_b;
  logic        selfchk_err_b;

  des_final_perm_stage #(.SWAP_HALVES(1'b1), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .blk_count   (blk_count),
    .selfchk_err (selfchk_err)
  );

  des_final_perm_stage #(.SWAP_HALVES(1'b0), .CNT_W(16)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_b),
    .blk_count   (blk_count_b),
    .selfchk_err (selfchk_err_b)
  );

  int checks = 0;
  int failures = 0;
  des_block_t mq[$];
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic des_block_t sw(input des_block_t b);
    return {b[33:64], b[1:32]};
  endfunction

  function automatic des_block_t rnd_blk();
    return {$urandom, $urandom};
  endfunction

  // One clock edge; the model applies the same transfer rules as the stage.
  task automatic cycle(output bit pushed);
    bit push, pop;
    push = bus.in_valid && (mq.size() < 2);
    pop  = bus.out_ready && (mq.size() > 0);
    @(posedge clk);
    if (pop) begin
      void'(mq.pop_front());
      exp_cnt++;
    end
    if (push) mq.push_back(sw(bus.in_block));
    pushed = push;
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'(mq.size() < 2));
    chk({tag, "_vld"}, 64'(bus.out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, "_data"}, des_ip(bus.out_block), mq[0]);
    chk({tag, "_cnt"}, 64'(blk_count), 64'(exp_cnt[3:0]));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();
    exp_cnt = 0;
    chk({tag, "_rst_rdy"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_rst_vld"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_rst_blk"}, bus.out_block, 64'd0);
    chk({tag, "_rst_cnt"}, 64'(blk_count), 64'd0);
    chk({tag, "_rst_err"}, 64'(selfchk_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_post_rdy"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p;
    des_block_t x;
    des_block_t blk_c;
    bit c_taken;

    bus.in_valid = 1'b0;
    bus.in_block = '0;
    bus.out_ready = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_b.in_block = '0;
    bus_b.out_ready = 1'b1;

    do_reset("init");

    // Inverse check on the no-swap instance.
    bus_b.in_block = 64'hCC00CCFFF0AAF0AA;
    bus_b.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
    chk("inv_vld", 64'(bus_b.out_valid), 64'd1);
    chk("inv_kv", bus_b.out_block, 64'h0123456789ABCDEF);
    for (int i = 0; i < 8; i++) begin
      x = rnd_blk();
      bus_b.in_block = x;
      bus_b.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_b.in_valid = 1'b0;
      chk("inv_rand", des_ip(bus_b.out_block), x);
    end
    @(posedge clk);
    #1;
    chk("inv_cnt", 64'(blk_count_b), 64'd9);

    // Known vector with half swap.
    bus.in_block = 64'h434232340A4CD995;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    cycle(p);
    bus.in_valid = 1'b0;
    chk("kv_out", bus.out_block, 64'h85E813540F0AB405);
    chk("kv_vld", 64'(bus.out_valid), 64'd1);
    cycle(p);
    chk("kv_cnt", 64'(blk_count), 64'd1);
    check_state("kv_idle");

    // Backpressure: A, B accepted, C held.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_block = 64'h0123456789ABCDEF;
    cycle(p);
    check_state("bp_a");
    bus.in_block = 64'hFEDCBA9876543210;
    cycle(p);
    check_state("bp_b");
    blk_c = 64'hA5A5A5A55A5A5A5A;
    bus.in_block = blk_c;
    for (int i = 0; i < 3; i++) begin
      cycle(p);
      chk("bp_c_held", 64'(p), 64'd0);
      check_state("bp_full");
    end
    bus.out_ready = 1'b1;
    c_taken = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(p);
      if (p) c_taken = 1'b1;
      if (c_taken) bus.in_valid = 1'b0;
      check_state("bp_drain");
    end
    chk("bp_c_taken", 64'(c_taken), 64'd1);
    chk("bp_all_out", 64'(blk_count), 64'd4);
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // Fill to 2, then push with random out_ready.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_block = rnd_blk();
      cycle(p);
    end
    check_state("sim_full");
    for (int i = 0; i < 20; i++) begin
      bus.in_block = rnd_blk();
      bus.out_ready = 1'($urandom_range(0, 1));
      cycle(p);
      check_state("sim_rand");
    end
    // Occupancy 1 with push and pop each cycle.
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4 && mq.size() > 1; i++) cycle(p);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_block = rnd_blk();
      cycle(p);
      check_state("sim_occ1");
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle(p);
    check_state("sim_done");

    // Counter wrap, CNT_W = 4.
    do_reset("wrap");
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_cnt < 16; i++) begin
      bus.in_block = rnd_blk();
      cycle(p);
      check_state("wrap_run");
    end
    chk("wrap16", 64'(blk_count), 64'd0);
    for (int i = 0; i < 5 && exp_cnt < 17; i++) begin
      bus.in_block = rnd_blk();
      cycle(p);
    end
    bus.in_valid = 1'b0;
    chk("wrap17", 64'(blk_count), 64'd1);

    // Reset mid-stream at occupancy 2.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_block = rnd_blk();
      cycle(p);
    end
    check_state("mid_full");
    do_reset("mid");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(p);
      chk("mid_no_stale", 64'(bus.out_valid), 64'd0);
    end

`ifdef DES_FP_SELFCHECK_EN
    // Corrupt the stored preoutput of a buffered entry (pre bit 64 is 0).
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_block = 64'h1111111022222222;
    cycle(p);
    bus.in_valid = 1'b0;
    force dut.u_fifo.slot0_q[0] = 1'b1;
    #1;
    bus.out_ready = 1'b1;
    cycle(p);
    release dut.u_fifo.slot0_q[0];
    chk("selfchk_set", 64'(selfchk_err), 64'd1);
    for (int i = 0; i < 3; i++) cycle(p);
    chk("selfchk_sticky", 64'(selfchk_err), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
